pipe_stage_buffer: RTL

Parametrised elastic pipeline register, the successor to the fixed IF/ID latch between pipeline stages. It carries instruction, immediate, PC and next-PC fields across a stage boundary. It uses a valid/ready handshake, so back-pressure stalls the upstream stage without dropping a word. A two-entry skid structure gives full throughput, and a synchronous flush inserts a zero bubble for branch and jump squashing.

---
 rtl/pipe_stage_buffer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/pipe_stage_buffer.sv
// -----------------------------------------------------------------------------
// pipe_stage_buffer
//
// Elastic two-entry pipeline register carrying instruction, immediate, PC and
// next-PC across a stage boundary with a valid/ready handshake. A main
// register drives the outputs and a skid register absorbs one overflow word,
// so the stage sustains one word per cycle and back-pressure never drops a
// word. A synchronous flush squashes everything held and leaves a zero bubble.
//
// Optional feature macro: PIPE_STAGE_STALL_CNT_EN
//   When defined, adds the stallCount port: a saturating count of cycles in
//   which a valid word was held back by the downstream stage.
//
// Parameters:
//   INSTR_W  instruction field width
//   IMM_W    immediate field width
//   PC_W     PC / next-PC width
//   CNT_W    stall counter width (only meaningful with the macro)
//
// Ports:
//   clk          clock, all state updates on posedge
//   rstN         asynchronous active-low reset
//   flush        synchronous squash of all held words
//   inValid      upstream word present
//   inReady      buffer can accept a word this cycle
//   instruction, imm, pc, nextPC   upstream payload
//   outValid     o* outputs hold a valid word
//   outReady     downstream consumes the word this cycle
//   oInstruction, oImm, oPc, oNextPC   held payload (all zero when empty)
//   stallCount   saturating stall-cycle count (macro only)
// -----------------------------------------------------------------------------
module pipe_stage_buffer #(
  parameter int INSTR_W = 16,
  parameter int IMM_W   = 16,
  parameter int PC_W    = 32,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rstN,
  input  logic               flush,
  input  logic               inValid,
  output logic               inReady,
  input  logic [INSTR_W-1:0] instruction,
  input  logic [IMM_W-1:0]   imm,
  input  logic [PC_W-1:0]    pc,
  input  logic [PC_W-1:0]    nextPC,
  output logic               outValid,
  input  logic               outReady,
  output logic [INSTR_W-1:0] oInstruction,
  output logic [IMM_W-1:0]   oImm,
  output logic [PC_W-1:0]    oPc,
  output logic [PC_W-1:0]    oNextPC
`ifdef PIPE_STAGE_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]   stallCount
`endif
);

  localparam int PW = INSTR_W + IMM_W + 2 * PC_W;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [PW-1:0]   main_reg, main_next;
  logic [PW-1:0]   skid_reg, skid_next;
  logic [PW-1:0]   in_word;
  logic            accept;
  logic            take;

  assign in_word = {instruction, imm, pc, nextPC};

  // Handshake flags depend only on the registered state, so there is no
  // combinational path from inValid/outReady to inReady/outValid.
  assign inReady  = (state_reg != ST_TWO);
  assign outValid = (state_reg != ST_EMPTY);

  assign accept = inValid & inReady;
  assign take   = outValid & outReady;

  // main_reg is kept at zero whenever the buffer is empty, which makes the
  // outputs a NOP bubble without any output-side masking.
  assign {oInstruction, oImm, oPc, oNextPC} = main_reg;

  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;

    if (flush) begin
      // A word taken in this cycle has already been seen downstream; the
      // buffer discards everything it holds plus any same-cycle input.
      state_next = ST_EMPTY;
      main_next  = '0;
      skid_next  = '0;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (accept) begin
            main_next  = in_word;
            state_next = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && take) begin
            main_next = in_word;
          end else if (accept) begin
            skid_next  = in_word;
            state_next = ST_TWO;
          end else if (take) begin
            main_next  = '0;
            state_next = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // inReady is low here, so upstream input is not looked at.
          if (take) begin
            main_next  = skid_reg;
            skid_next  = '0;
            state_next = ST_ONE;
          end
        end
        default: begin
          state_next = ST_EMPTY;
          main_next  = '0;
          skid_next  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_reg <= ST_EMPTY;
      main_reg  <= '0;
      skid_reg  <= '0;
    end else begin
      state_reg <= state_next;
      main_reg  <= main_next;
      skid_reg  <= skid_next;
    end
  end

`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_reg;

  // Counts cycles where a valid word is held back; sticks at all-ones.
  // Only reset clears it so that flushes do not hide stall history.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      stall_cnt_reg <= '0;
    end else if (outValid && !outReady && (stall_cnt_reg != {CNT_W{1'b1}})) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign stallCount = stall_cnt_reg;
`else
  // CNT_W has no consumer when the counter is compiled out.
  logic unused_cnt_w;
  assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule
